results_drain: RTL and testbench
================================

# results_drain

Read-side controller for the results SRAM: on a start command it reads a contiguous range of result words out of the single-port results buffer and streams them to the downstream consumer (host DMA or output serializer) over a valid/ready interface. It absorbs the SRAM's one-cycle read latency and downstream backpressure with a 2-entry output buffer, and optionally zeroes each location after it is read so the buffer is clean for the next accumulation pass. It owns the SRAM port while `busy`; the write-side producer must not touch the port during that time.

## Interface
- `ADDRESSSIZE`, 10, SRAM address width
- `WORDSIZE`, 160, result word width (8 lanes x 20 bit)
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle command pulse; ignored while `busy`
- `base_addr` in ADDRESSSIZE: first address, sampled with `start`
- `count` in ADDRESSSIZE+1: words to drain, sampled with `start`; 0 is legal
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse when the command completes
- `mem_write_enable` out 1: to SRAM `write_enable`
- `mem_address` out ADDRESSSIZE: to SRAM `address`
- `mem_wdata` out WORDSIZE: to SRAM `data_in`, constant zero
- `mem_rdata` in WORDSIZE: from SRAM `data_out`
- `out_valid` out 1, `out_ready` in 1, `out_data` out WORDSIZE, `out_last` out 1 (high on final word)

## Operation
- FSM states: IDLE, READ, CLEAR (only with macro), FLUSH.
- IDLE: `start` latches `base_addr`/`count`, clears issue and beat counters; `count`=0 -> `done` pulses on the next cycle, no SRAM access, back to IDLE; otherwise -> READ.
- READ: when issue counter < count and `occupancy + inflight - pop < 2`, drive `mem_address` = base + issue (modulo 2^ADDRESSSIZE, wraps silently), `mem_write_enable`=0, set inflight, increment issue. Otherwise hold address, no issue.
- Captured word enters the buffer on the edge after the read cycle.
- After the last issue -> FLUSH; FLUSH waits until the final beat is accepted (`out_valid && out_ready && out_last`), then pulses `done`, -> IDLE.
- `out_last` asserted exactly with the word whose beat index = count-1.
- `out_data` is stable while `out_valid && !out_ready`.
- `start` while busy: ignored, no effect on the running command.
- Reset mid-command: all state to reset values immediately; buffered words discarded; no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `mem_write_enable`=0, `mem_address`=0, FSM IDLE.
- Start sampled at edge E0 -> first read address driven after E0 -> SRAM samples at E1 -> word captured at E2 -> `out_valid` high after E2 (2-edge latency).
- With `out_ready` held high and no clear: one word per cycle sustained; `done` one cycle after the last handshake.
- `out_ready` low: at most 2 words buffered, reads stall; no word lost or duplicated.

## Configuration
- `RESULTS_DRAIN_CLEAR_EN` defined: every read cycle for address A is followed by a CLEAR cycle driving address A with `mem_write_enable`=1 (zero data); SRAM holds `data_out` during the write so capture is unaffected; throughput at most 1 word / 2 cycles; `done` only after the final clear write.
- Undefined: no CLEAR state, `mem_write_enable` tied 0, full rate.

## Structure
- Package `results_drain_pkg`: FSM state enum, default `ADDRESSSIZE`/`WORDSIZE` constants, lane width constant (20).
- One sub-module: `results_drain_fifo`, 2-entry synchronous FIFO carrying data + last flag, exposing occupancy and pop.

## Test plan
- base=5, count=4, SRAM preloaded A[i]=i+100, `out_ready`=1 -> words 105..108 order, `out_last` on 108, first `out_valid` 2 edges after start, `done` after final handshake.
- count=0 -> `done` pulse next cycle, `mem_address`/`mem_write_enable` never change, no `out_valid`.
- base=1022, count=4 -> addresses 1022,1023,0,1 read in order.
- count=8, `out_ready` toggling pseudo-randomly -> all 8 words exactly once, `out_data` stable during stalls, never >2 reads outstanding.
- `RESULTS_DRAIN_CLEAR_EN`, base=0, count=3 -> correct data out, addresses 0..2 read back as zero afterwards, 2 cycles per word.
- `rst` asserted mid-stream after 2 beats -> outputs at reset values immediately, no `done`; new start after reset runs cleanly.

Source files
------------

// File: rtl/results_drain_pkg.sv
// Shared types and default sizes for the results-buffer drain controller.
package results_drain_pkg;

    localparam int LANE_W          = 20;
    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_WORDSIZE    = 8 * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/results_drain_fifo.sv
// Two-entry output buffer for drained result words plus their last-beat flag.
module results_drain_fifo
    import results_drain_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WORDSIZE-1:0] push_data,
    input  logic                push_last,
    input  logic                pop,
    output logic [WORDSIZE-1:0] pop_data,
    output logic                pop_last,
    output logic                valid,
    output logic [1:0]          occupancy
);

    logic [WORDSIZE-1:0] data_q [2];
    logic                last_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          occ_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage is not reset; the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= push_data;
            last_q[wr_ptr_q] <= push_last;
        end
    end

    assign valid     = (occ_q != 2'd0);
    assign occupancy = occ_q;
    assign pop_data  = valid ? data_q[rd_ptr_q] : '0;
    assign pop_last  = valid & last_q[rd_ptr_q];

endmodule

// File: rtl/results_drain.sv
// Streams a contiguous range of results-SRAM words to a valid/ready consumer.
// Define RESULTS_DRAIN_CLEAR_EN to zero each location right after it is read.
module results_drain
    import results_drain_pkg::*;
#(
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int WORDSIZE    = DEF_WORDSIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE:0]   count,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_write_enable,
    output logic [ADDRESSSIZE-1:0] mem_address,
    output logic [WORDSIZE-1:0]    mem_wdata,
    input  logic [WORDSIZE-1:0]    mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDSIZE-1:0]    out_data,
    output logic                   out_last
);

    state_t                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ADDRESSSIZE-1:0] addr_q;
    logic [ADDRESSSIZE:0]   count_q;
    logic [ADDRESSSIZE:0]   issue_q;
    logic [ADDRESSSIZE:0]   issue_nxt;
    logic                   inflight_q;
    logic                   inflight_last_q;
    logic                   done_q;
    logic                   issue;
    logic                   fifo_pop;
    logic                   fifo_last;
    logic [1:0]             occ;
    logic [2:0]             level;

    assign issue_nxt = issue_q + {{ADDRESSSIZE{1'b0}}, 1'b1};
    assign fifo_pop  = out_valid & out_ready;
    // Words that will sit in the buffer once this cycle's capture and pop settle.
    assign level     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, fifo_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        issue            = 1'b0;
        mem_address      = addr_q;
        mem_write_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (count != '0)) state_d = ST_READ;
            end
            ST_READ: begin
                if ((issue_q < count_q) && (level < 3'd2)) begin
                    issue       = 1'b1;
                    mem_address = base_q + issue_q[ADDRESSSIZE-1:0];
`ifdef RESULTS_DRAIN_CLEAR_EN
                    state_d     = ST_CLEAR;
`else
                    if (issue_nxt == count_q) state_d = ST_FLUSH;
`endif
                end
            end
`ifdef RESULTS_DRAIN_CLEAR_EN
            // Re-drive the address just read; the SRAM keeps data_out stable during the write.
            ST_CLEAR: begin
                mem_write_enable = 1'b1;
                state_d          = (issue_q == count_q) ? ST_FLUSH : ST_READ;
            end
`endif
            ST_FLUSH: begin
                if (fifo_pop && fifo_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q          <= '0;
            addr_q          <= '0;
            count_q         <= '0;
            issue_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && (issue_nxt == count_q);
            if (state_q == ST_IDLE && start) begin
                base_q  <= base_addr;
                count_q <= count;
                issue_q <= '0;
                done_q  <= (count == '0);
            end
            if (issue) begin
                issue_q <= issue_nxt;
                addr_q  <= mem_address;
            end
            if (state_q == ST_FLUSH && fifo_pop && fifo_last) done_q <= 1'b1;
        end
    end

    results_drain_fifo #(
        .WORDSIZE (WORDSIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mem_rdata),
        .push_last (inflight_last_q),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .pop_last  (fifo_last),
        .valid     (out_valid),
        .occupancy (occ)
    );

    assign out_last  = fifo_last;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign mem_wdata = '0;

endmodule

// File: tb/tb_results_drain.sv
// Randomised bench for results_drain against a queue-based model of the drained words.
module tb_results_drain;

    localparam int AW = 10;
    localparam int WW = 160;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_data;
    logic          out_last;

    results_drain #(.ADDRESSSIZE(AW), .WORDSIZE(WW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base_addr        (base_addr),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: registered read, data_out held during a write.
    logic [WW-1:0] sram [1024];
    always @(posedge clk) begin
        if (mem_write_enable) sram[mem_address] <= mem_wdata;
        else                  mem_rdata <= sram[mem_address];
    end

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    beats_seen = 0;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor: handshakes are sampled mid-cycle and matched in order.
    logic          prev_stall = 1'b0;
    logic [WW-1:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", out_data, mon_e.data);
                    chk("beat_last", out_last, mon_e.last);
                end
                beats_seen++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic load_expected(input logic [AW-1:0] b, input int c);
        beat_t e;
        for (int i = 0; i < c; i++) begin
            e.data = sram[AW'(int'(b) + i)];
            e.last = (i == c - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input int c, input bit rmode, input bit poke);
        int cyc;
        int first_v;
        int done_cyc;
        int exp_done;
        bit we_seen;
        load_expected(b, c);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; count = (AW+1)'(c);
        @(posedge clk); #1;
        start = 1'b0;
        first_v = -1; done_cyc = -1; we_seen = 1'b0;
        for (cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && cyc == 3) begin
                start = 1'b1; base_addr = 10'd999; count = 11'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) chk("busy_run", busy, 1'b1);
            if (out_valid && first_v < 0) first_v = cyc;
            if (mem_write_enable) we_seen = 1'b1;
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_seen", done_cyc >= 0, 1'b1);
        chk("drained", exp_q.size(), 0);
        chk("idle_after", busy, 1'b0);
`ifdef RESULTS_DRAIN_CLEAR_EN
        exp_done = 2 * c + 1;
        chk("we_used", we_seen, 1'b1);
        for (int i = 0; i < c; i++) chk("cleared", sram[AW'(int'(b) + i)], '0);
`else
        exp_done = c + 2;
        chk("we_idle", we_seen, 1'b0);
`endif
        if (!rmode) begin
            chk("first_valid_lat", first_v, 2);
            chk("done_lat", done_cyc, exp_done);
        end
    endtask

    logic [AW-1:0] addr0;
    bit            bad;
    int            lim;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) sram[i] = WW'(i + 100);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_we", mem_write_enable, 1'b0);
        chk("rst_addr", mem_address, '0);
        rst = 1'b0;

        run_cmd(10'd5, 4, 1'b0, 1'b0);
        run_cmd(10'd1022, 4, 1'b0, 1'b0);
        run_cmd(10'd40, 8, 1'b1, 1'b0);
        run_cmd(10'd60, 8, 1'b0, 1'b1);

        // Zero-length command.
        addr0 = mem_address;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd77; count = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_addr", mem_address, addr0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid || mem_write_enable || mem_address != addr0) bad = 1'b1;
        end
        chk("zero_quiet", bad, 1'b0);

        // Reset in the middle of a stream after two beats.
        load_expected(10'd200, 8);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd200; count = 11'd8; out_ready = 1'b1;
        lim = beats_seen + 2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50 && beats_seen < lim; k++) @(negedge clk);
        chk("mid_two_beats", beats_seen >= lim, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_valid", out_valid, 1'b0);
        chk("mid_last", out_last, 1'b0);
        chk("mid_data", out_data, '0);
        chk("mid_we", mem_write_enable, 1'b0);
        chk("mid_addr", mem_address, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || out_valid) bad = 1'b1;
        end
        chk("mid_no_done", bad, 1'b0);
        run_cmd(10'd300, 5, 1'b0, 1'b0);

        // Clear path (or untouched memory in the default build), then read back.
        run_cmd(10'd0, 3, 1'b0, 1'b0);
        run_cmd(10'd0, 3, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) sram[$urandom_range(0, 1023)] = {$urandom, $urandom, $urandom, $urandom, $urandom};
            run_cmd(AW'($urandom_range(0, 1023)), $urandom_range(1, 12), 1'b1, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
